game_ctrl: RTL and testbench

//  Match sequencer for the pong datapath; runs on the 25 MHz pixel clock.

---
 rtl/game_ctrl_pkg.sv | 17 +
 rtl/game_ctrl_rise_edge.sv | 21 ++
 rtl/game_ctrl.sv | 176 +++++++++++++++++
 tb/tb_game_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the pong match sequencer: FSM state encodings and winner codes.
package game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_POINT  = 3'd3,
        ST_OVER   = 3'd4,
        ST_PAUSED = 3'd5
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/game_ctrl_rise_edge.sv
// 1-bit rising-edge detector; the previous-value register resets to RST_VAL so a
// level held high through reset does not produce an edge.
module rise_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= RST_VAL;
        else     prev <= din;
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/game_ctrl.sv
// Pong match sequencer: gates paddle/ball motion, serves, scores and declares a winner.
// Optional pause button and PAUSED state are built when PONG_PAUSE_EN is defined.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30,
    parameter int CNT_W        = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_start,
`ifdef PONG_PAUSE_EN
    input  logic       btn_pause,
`endif
    input  logic       miss_l,
    input  logic       miss_r,
    output logic       paddle_en,
    output logic       ball_en,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam logic [3:0]       WIN_S    = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] SERVE_LD = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0] POINT_LD = CNT_W'(POINT_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           cur_state, nxt_state;
    logic [CNT_W-1:0] cnt_q, nxt_cnt;
    logic             nxt_paddle_en, nxt_ball_en, nxt_ball_reset, nxt_serve_dir;
    logic [3:0]       nxt_score_p1, nxt_score_p2;
    logic [1:0]       nxt_winner;
    logic             start_edge, pause_edge;
    logic             hit_p1, hit_p2, cnt_done;

    rise_edge #(.RST_VAL(1'b1)) u_start_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_start),
        .rise (start_edge)
    );

`ifdef PONG_PAUSE_EN
    state_t saved_state;

    rise_edge #(.RST_VAL(1'b1)) u_pause_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_pause),
        .rise (pause_edge)
    );

    always_ff @(posedge clk) begin
        if (rst)                                          saved_state <= ST_IDLE;
        else if (nxt_state == ST_PAUSED && cur_state != ST_PAUSED) saved_state <= cur_state;
    end
`else
    assign pause_edge = 1'b0;
`endif

    // cnt_done also covers cnt==0 so the countdown can never wrap.
    assign cnt_done = (cnt_q <= CNT_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state  <= ST_IDLE;
            cnt_q      <= '0;
            paddle_en  <= 1'b0;
            ball_en    <= 1'b0;
            ball_reset <= 1'b0;
            serve_dir  <= 1'b0;
            score_p1   <= 4'd0;
            score_p2   <= 4'd0;
            winner     <= WIN_NONE;
        end else begin
            cur_state  <= nxt_state;
            cnt_q      <= nxt_cnt;
            paddle_en  <= nxt_paddle_en;
            ball_en    <= nxt_ball_en;
            ball_reset <= nxt_ball_reset;
            serve_dir  <= nxt_serve_dir;
            score_p1   <= nxt_score_p1;
            score_p2   <= nxt_score_p2;
            winner     <= nxt_winner;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        hit_p1    = 1'b0;
        hit_p2    = 1'b0;
        case (cur_state)
            ST_IDLE:  if (start_edge) nxt_state = ST_SERVE;
            ST_SERVE: begin
                if (pause_edge)                  nxt_state = ST_PAUSED;
                else if (frame_tick && cnt_done) nxt_state = ST_PLAY;
            end
            ST_PLAY: begin
                // A miss outranks both the frame tick and a pause press.
                if (miss_l ^ miss_r) begin
                    hit_p1 = miss_r;
                    hit_p2 = miss_l;
                    if ((miss_r && (score_p1 + 4'd1 == WIN_S)) ||
                        (miss_l && (score_p2 + 4'd1 == WIN_S)))
                        nxt_state = ST_OVER;
                    else
                        nxt_state = ST_POINT;
                end else if (miss_l && miss_r) begin
                    nxt_state = ST_POINT;
                end else if (pause_edge) begin
                    nxt_state = ST_PAUSED;
                end
            end
            ST_POINT: if (frame_tick && cnt_done) nxt_state = ST_SERVE;
            ST_OVER:  if (start_edge) nxt_state = ST_IDLE;
`ifdef PONG_PAUSE_EN
            ST_PAUSED: if (pause_edge) nxt_state = saved_state;
`endif
            default:  nxt_state = ST_IDLE;
        endcase
    end

    always_comb begin
        nxt_cnt        = cnt_q;
        nxt_ball_reset = 1'b0;
        nxt_serve_dir  = serve_dir;
        nxt_score_p1   = score_p1;
        nxt_score_p2   = score_p2;
        nxt_winner     = winner;
        nxt_paddle_en  = (nxt_state == ST_SERVE) || (nxt_state == ST_PLAY) ||
                         (nxt_state == ST_POINT);
        nxt_ball_en    = (nxt_state == ST_PLAY);
        case (cur_state)
            ST_IDLE: if (nxt_state == ST_SERVE) begin
                nxt_score_p1   = 4'd0;
                nxt_score_p2   = 4'd0;
                nxt_winner     = WIN_NONE;
                nxt_ball_reset = 1'b1;
                nxt_cnt        = SERVE_LD;
            end
            ST_SERVE: if (nxt_state == ST_SERVE && frame_tick && cnt_q != '0)
                nxt_cnt = cnt_q - CNT_ONE;
            ST_PLAY: begin
                if (hit_p1) begin
                    if (score_p1 < WIN_S) nxt_score_p1 = score_p1 + 4'd1;
                    nxt_serve_dir = 1'b1;
                end
                if (hit_p2) begin
                    if (score_p2 < WIN_S) nxt_score_p2 = score_p2 + 4'd1;
                    nxt_serve_dir = 1'b0;
                end
                if (nxt_state == ST_OVER)  nxt_winner = hit_p1 ? WIN_P1 : WIN_P2;
                if (nxt_state == ST_POINT) nxt_cnt = POINT_LD;
            end
            ST_POINT: begin
                if (nxt_state == ST_SERVE) begin
                    nxt_ball_reset = 1'b1;
                    nxt_cnt        = SERVE_LD;
                end else if (frame_tick && cnt_q != '0) begin
                    nxt_cnt = cnt_q - CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl (WIN_SCORE=3, SERVE_FRAMES=3, POINT_FRAMES=2).
module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       rst, frame_tick, btn_start, miss_l, miss_r;
    logic       btn_pause;
    logic       paddle_en, ball_en, ball_reset, serve_dir;
    logic [3:0] score_p1, score_p2;
    logic [1:0] winner;
    logic [2:0] state;
    int         tests = 0;
    int         fails = 0;

    always #20 clk = ~clk;

    game_ctrl #(
        .WIN_SCORE    (3),
        .SERVE_FRAMES (3),
        .POINT_FRAMES (2),
        .CNT_W        (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .btn_start  (btn_start),
`ifdef PONG_PAUSE_EN
        .btn_pause  (btn_pause),
`endif
        .miss_l     (miss_l),
        .miss_r     (miss_r),
        .paddle_en  (paddle_en),
        .ball_en    (ball_en),
        .ball_reset (ball_reset),
        .serve_dir  (serve_dir),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .winner     (winner),
        .state      (state)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cycle();
            frame_tick = 1'b0;
        end
    endtask

    task automatic press_start();
        btn_start = 1'b0;
        cycle();
        btn_start = 1'b1;
        cycle();
    endtask

    task automatic miss(input logic l, input logic r);
        miss_l = l;
        miss_r = r;
        cycle();
        miss_l = 1'b0;
        miss_r = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; btn_start = 1'b1;
        miss_l = 1'b0; miss_r = 1'b0; btn_pause = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        chk("rst_state", {5'd0, state}, 8'd0);
        chk("rst_en", {6'd0, paddle_en, ball_en}, 8'd0);
        chk("rst_scores", {score_p1, score_p2}, 8'h00);
        chk("rst_misc", {5'd0, ball_reset, winner}, 8'd0);
        chk("rst_dir", {7'd0, serve_dir}, 8'd0);
        cycle(); cycle();
        chk("held_btn_no_start", {5'd0, state}, 8'd0);

        press_start();
        chk("start_serve", {5'd0, state}, 8'd1);
        chk("start_ball_reset", {7'd0, ball_reset}, 8'd1);
        chk("serve_en", {6'd0, paddle_en, ball_en}, 8'b10);
        cycle();
        chk("ball_reset_one_cycle", {7'd0, ball_reset}, 8'd0);
        press_start();
        chk("start_ignored_serve", {5'd0, state}, 8'd1);
        ticks(2);
        chk("serve_after_2", {5'd0, state}, 8'd1);
        ticks(1);
        chk("play_state", {5'd0, state}, 8'd2);
        chk("play_en", {6'd0, paddle_en, ball_en}, 8'b11);

        miss(1'b0, 1'b1);
        chk("miss_r_state", {5'd0, state}, 8'd3);
        chk("miss_r_score", {score_p1, score_p2}, 8'h10);
        chk("miss_r_dir", {7'd0, serve_dir}, 8'd1);
        chk("point_en", {6'd0, paddle_en, ball_en}, 8'b10);
        ticks(1);
        chk("point_after_1", {5'd0, state}, 8'd3);
        ticks(1);
        chk("point_to_serve", {5'd0, state}, 8'd1);
        chk("point_ball_reset", {7'd0, ball_reset}, 8'd1);
        cycle();
        chk("point_ball_reset_off", {7'd0, ball_reset}, 8'd0);
        ticks(3);
        chk("play_again", {5'd0, state}, 8'd2);

        miss(1'b1, 1'b1);
        chk("both_state", {5'd0, state}, 8'd3);
        chk("both_scores", {score_p1, score_p2}, 8'h10);
        chk("both_dir", {7'd0, serve_dir}, 8'd1);
        miss(1'b1, 1'b0);
        chk("miss_in_point_ignored", {score_p1, score_p2}, 8'h10);
        ticks(2); ticks(3);

        miss(1'b1, 1'b0);
        chk("p2_pt1", {score_p1, score_p2}, 8'h11);
        chk("p2_dir", {7'd0, serve_dir}, 8'd0);
        ticks(2); ticks(3);
        miss(1'b1, 1'b0);
        chk("p2_pt2", {score_p1, score_p2}, 8'h12);
        chk("p2_pt2_state", {5'd0, state}, 8'd3);
        ticks(2); ticks(3);
        frame_tick = 1'b1;
        miss(1'b1, 1'b0);
        frame_tick = 1'b0;
        chk("over_state", {5'd0, state}, 8'd4);
        chk("over_scores", {score_p1, score_p2}, 8'h13);
        chk("over_winner", {6'd0, winner}, 8'b10);
        chk("over_en", {6'd0, paddle_en, ball_en}, 8'b00);
        miss(1'b1, 1'b0);
        miss(1'b0, 1'b1);
        chk("over_miss_ignored", {score_p1, score_p2}, 8'h13);
        chk("over_held", {5'd0, state}, 8'd4);

        press_start();
        chk("over_to_idle", {5'd0, state}, 8'd0);
        chk("idle_winner_held", {6'd0, winner}, 8'b10);
        chk("idle_scores_held", {score_p1, score_p2}, 8'h13);
        press_start();
        chk("restart_serve", {5'd0, state}, 8'd1);
        chk("restart_scores", {score_p1, score_p2}, 8'h00);
        chk("restart_winner", {6'd0, winner}, 8'b00);

`ifdef PONG_PAUSE_EN
        ticks(1);
        btn_pause = 1'b1;
        cycle();
        chk("paused_state", {5'd0, state}, 8'd5);
        chk("paused_en", {6'd0, paddle_en, ball_en}, 8'b00);
        btn_pause = 1'b0;
        ticks(5);
        chk("paused_ticks_ignored", {5'd0, state}, 8'd5);
        btn_pause = 1'b1;
        cycle();
        btn_pause = 1'b0;
        chk("unpause_serve", {5'd0, state}, 8'd1);
        ticks(1);
        chk("unpause_one_tick", {5'd0, state}, 8'd1);
        ticks(1);
        chk("unpause_play", {5'd0, state}, 8'd2);
`else
        ticks(3);
        chk("restart_play", {5'd0, state}, 8'd2);
`endif

        miss(1'b0, 1'b1);
        chk("pre_abort_score", {score_p1, score_p2}, 8'h10);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("abort_state", {5'd0, state}, 8'd0);
        chk("abort_scores", {score_p1, score_p2}, 8'h00);
        chk("abort_dir", {7'd0, serve_dir}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
